vc_pop_arbiter: RTL and testbench

- Downstream consumer of two 6x8 virtual-channel FIFOs: VC0 is high priority, VC1 is low priority.
- Each cycle it decides which FIFO to pop, captures the popped byte and routes it to one of four destination FIFO push ports, selected by the byte's top two bits.
- It honours destination back-pressure and includes an anti-starvation rule for VC1.

---
 rtl/vc_pop_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_vc_pop_arbiter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: drains two priority VC FIFOs (VC0 high, VC1 low) and routes each word to one of four destinations.
// Latency: 2 cycles from pop to push_dst; back-to-back pops sustain one push per cycle.
// Backpressure: any destination almost_full stops new pops the same cycle; up to 2 in-flight words still complete.
// Optional build macro ARB_COUNTERS_EN adds per-VC forwarded-word counters (cnt_vc0/cnt_vc1), otherwise tied to 0.

module vc_pop_arbiter #(
    parameter int DATA_SIZE  = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty_vc0,
    input  logic                 almost_empty_vc0,
    input  logic [DATA_SIZE-1:0] data_vc0,
    output logic                 pop_vc0,
    input  logic                 fifo_empty_vc1,
    input  logic                 almost_empty_vc1,
    input  logic [DATA_SIZE-1:0] data_vc1,
    output logic                 pop_vc1,
    input  logic [3:0]           almost_full_dst,
    output logic [3:0]           push_dst,
    output logic [DATA_SIZE-1:0] data_out,
    output logic [1:0]           arb_state,
    output logic [7:0]           cnt_vc0,
    output logic [7:0]           cnt_vc1
);

    // Starvation counter only needs to reach STARVE_MAX.
    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [SW-1:0]        starve_q, starve_d;

    // Pop history doubles as pipeline stage 1: a pop last cycle means the
    // FIFO's data_out_pop carries that word during this cycle.
    logic                 pop0_q, pop1_q;

    // Stage 2: registered push strobe and word.
    logic [3:0]           push_q;
    logic [DATA_SIZE-1:0] data_q;

    logic                 pause;
    logic                 elig0, elig1;
    logic                 serve_ok;
    logic                 force_vc1;
    logic                 gnt0, gnt1;
    logic                 s1_vld;
    logic                 inflight;
    logic [DATA_SIZE-1:0] sel_data;
    logic [1:0]           dst_sel;
    logic [3:0]           dst_oh;

    assign pause = |almost_full_dst;

    // A FIFO flagged almost-empty that was popped last cycle may be showing its
    // last word already consumed; its empty flag updates one cycle late.
    assign elig0 = !fifo_empty_vc0 && !(almost_empty_vc0 && pop0_q);
    assign elig1 = !fifo_empty_vc1 && !(almost_empty_vc1 && pop1_q);

    assign s1_vld   = pop0_q || pop1_q;
    assign inflight = s1_vld || (|push_q);

    assign sel_data = pop1_q ? data_vc1 : data_vc0;
    assign dst_sel  = sel_data[DATA_SIZE-1 -: 2];

    // Grant: VC0 wins unless VC1 has waited STARVE_MAX VC0 grants.
    always_comb begin
        serve_ok  = (state_q == ST_SERVE) && !pause;
        force_vc1 = (starve_q == STARVE_LIM) && elig1;
        gnt0      = serve_ok && elig0 && !force_vc1;
        gnt1      = serve_ok && elig1 && !gnt0;
    end

    assign pop_vc0 = gnt0;
    assign pop_vc1 = gnt1;

    // Starvation counter: counts VC0 grants taken while VC1 was waiting.
    always_comb begin
        starve_d = starve_q;
        if (gnt0 && elig1) begin
            if (starve_q != STARVE_LIM) begin
                starve_d = starve_q + SW'(1);
            end
        end else if (gnt1 || !elig1) begin
            starve_d = '0;
        end
    end

    // Next-state logic: HOLD always exits through SERVE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (elig0 || elig1) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (pause) begin
                    state_d = ST_HOLD;
                end else if (!elig0 && !elig1 && !inflight) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!pause) begin
                    state_d = ST_SERVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One-hot destination from the word's top two bits.
    always_comb begin
        dst_oh = 4'b0001 << dst_sel;
    end

    // Control registers: FSM state, starvation count and pop history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            pop0_q   <= 1'b0;
            pop1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            pop0_q   <= gnt0;
            pop1_q   <= gnt1;
        end
    end

    // Output stage: capture the popped word and strobe its destination for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_q <= 4'b0000;
            data_q <= '0;
        end else begin
            push_q <= 4'b0000;
            if (s1_vld) begin
                push_q <= dst_oh;
                data_q <= sel_data;
            end
        end
    end

    assign push_dst  = push_q;
    assign data_out  = data_q;
    assign arb_state = state_q;

`ifdef ARB_COUNTERS_EN
    logic       s2_vc1_q;
    logic [7:0] cnt0_q, cnt1_q;

    // Remember which VC the word now on data_out came from.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_vc1_q <= 1'b0;
        end else if (s1_vld) begin
            s2_vc1_q <= pop1_q;
        end
    end

    // Per-VC forwarded-word counters, wrapping at 8 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else if (|push_q) begin
            if (s2_vc1_q) begin
                cnt1_q <= cnt1_q + 8'd1;
            end else begin
                cnt0_q <= cnt0_q + 8'd1;
            end
        end
    end

    assign cnt_vc0 = cnt0_q;
    assign cnt_vc1 = cnt1_q;
`else
    assign cnt_vc0 = 8'd0;
    assign cnt_vc1 = 8'd0;
`endif

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Testbench for vc_pop_arbiter: two VC FIFO models feed the arbiter, a scoreboard checks every push.
// Expected words are queued per VC when loaded; pops are logged in order and matched against pushes.
// Each scenario task does its own inline comparisons; one summary line at the end.

module tb_vc_pop_arbiter;

    localparam int DW = 8;

`ifdef ARB_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          fifo_empty_vc0, almost_empty_vc0, pop_vc0;
    logic          fifo_empty_vc1, almost_empty_vc1, pop_vc1;
    logic [DW-1:0] data_vc0, data_vc1;
    logic [3:0]    almost_full_dst;
    logic [3:0]    push_dst;
    logic [DW-1:0] data_out;
    logic [1:0]    arb_state;
    logic [7:0]    cnt_vc0, cnt_vc1;

    vc_pop_arbiter #(.DATA_SIZE(DW), .STARVE_MAX(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .fifo_empty_vc0   (fifo_empty_vc0),
        .almost_empty_vc0 (almost_empty_vc0),
        .data_vc0         (data_vc0),
        .pop_vc0          (pop_vc0),
        .fifo_empty_vc1   (fifo_empty_vc1),
        .almost_empty_vc1 (almost_empty_vc1),
        .data_vc1         (data_vc1),
        .pop_vc1          (pop_vc1),
        .almost_full_dst  (almost_full_dst),
        .push_dst         (push_dst),
        .data_out         (data_out),
        .arb_state        (arb_state),
        .cnt_vc0          (cnt_vc0),
        .cnt_vc1          (cnt_vc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO models: flags follow pointers, data_out_pop registered on pop.
    logic [7:0] mem0 [0:1023];
    logic [7:0] mem1 [0:1023];
    int wr0, rd0, wr1, rd1;

    assign fifo_empty_vc0   = (wr0 == rd0);
    assign almost_empty_vc0 = ((wr0 - rd0) <= 1);
    assign fifo_empty_vc1   = (wr1 == rd1);
    assign almost_empty_vc1 = ((wr1 - rd1) <= 1);

    // Scoreboard state.
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    int         pend_vc  [$];
    int         pend_cyc [$];
    int         grant_log[$];
    logic [3:0] push_log [$];
    bit         lat0, lat1;
    int         cyc;
    int         pushed0, pushed1;
    int         errors, checks;

    task automatic load(input int vc, input logic [7:0] d);
        if (vc == 0) begin
            mem0[wr0] = d; wr0++; exp0.push_back(d);
        end else begin
            mem1[wr1] = d; wr1++; exp1.push_back(d);
        end
    endtask

    // One clock: monitor at negedge, FIFO model update just after posedge.
    task automatic tick();
        int         v, c;
        logic [7:0] e;
        @(negedge clk);
        if (reset) begin
            while (pend_vc.size() > 0) begin
                v = pend_vc.pop_front();
                c = pend_cyc.pop_front();
                if (v == 0 && exp0.size() > 0) e = exp0.pop_front();
                else if (v == 1 && exp1.size() > 0) e = exp1.pop_front();
            end
            lat0 = 1'b0; lat1 = 1'b0;
            pushed0 = 0; pushed1 = 0;
        end else begin
            lat0 = pop_vc0;
            lat1 = pop_vc1;
            checks++;
            if (lat0 && lat1) begin
                errors++;
                $display("FAIL dual_pop: pop_vc0=%0b pop_vc1=%0b, required at most one high", lat0, lat1);
            end
            if (lat0) begin pend_vc.push_back(0); pend_cyc.push_back(cyc); grant_log.push_back(0); end
            if (lat1) begin pend_vc.push_back(1); pend_cyc.push_back(cyc); grant_log.push_back(1); end
            if (push_dst != 4'b0000) begin
                push_log.push_back(push_dst);
                checks++;
                if (pend_vc.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_push: push_dst=%b data_out=%h, required no push", push_dst, data_out);
                end else begin
                    v = pend_vc.pop_front();
                    c = pend_cyc.pop_front();
                    e = 8'h00;
                    if (v == 0) begin
                        if (exp0.size() > 0) e = exp0.pop_front();
                        pushed0++;
                    end else begin
                        if (exp1.size() > 0) e = exp1.pop_front();
                        pushed1++;
                    end
                    if (data_out !== e) begin
                        errors++;
                        $display("FAIL push_data: vc%0d data_out=%h, required %h", v, data_out, e);
                    end
                    checks++;
                    if (push_dst !== (4'b0001 << e[7:6])) begin
                        errors++;
                        $display("FAIL push_dst: word %h push_dst=%b, required %b", e, push_dst, 4'b0001 << e[7:6]);
                    end
                    checks++;
                    if (cyc != c + 2) begin
                        errors++;
                        $display("FAIL latency: push in cycle %0d for pop in cycle %0d, required %0d", cyc, c, c + 2);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (lat0) begin
            checks++;
            if (rd0 == wr0) begin
                errors++;
                $display("FAIL underflow_vc0: pop with %0d words, required a word present", wr0 - rd0);
            end else begin
                data_vc0 = mem0[rd0]; rd0++;
            end
        end
        if (lat1) begin
            checks++;
            if (rd1 == wr1) begin
                errors++;
                $display("FAIL underflow_vc1: pop with %0d words, required a word present", wr1 - rd1);
            end else begin
                data_vc1 = mem1[rd1]; rd1++;
            end
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (pend_vc.size() == 0) && (exp0.size() == 0) && (exp1.size() == 0) && (arb_state == 2'd0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: not drained after %0d cycles (pending=%0d state=%0d), required drained", name, budget, pend_vc.size(), arb_state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({pop_vc0, pop_vc1, push_dst, data_out, arb_state, cnt_vc0, cnt_vc1} !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: pops=%b%b push=%b data=%h state=%0d cnt=%0d/%0d, required all 0", pop_vc0, pop_vc1, push_dst, data_out, arb_state, cnt_vc0, cnt_vc1);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({pop_vc0, pop_vc1, push_dst, arb_state} !== 8'h0) begin
                errors++;
                $display("FAIL idle_quiet: cycle %0d pops=%b%b push=%b state=%0d, required all 0", i, pop_vc0, pop_vc1, push_dst, arb_state);
            end
        end
    endtask

    task automatic test_vc0_stream();
        int g, p;
        logic [3:0] want [4];
        want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b1000;
        g = grant_log.size();
        p = push_log.size();
        load(0, 8'h05); load(0, 8'h47); load(0, 8'h8A); load(0, 8'hC3);
        wait_drain(40, "vc0_stream");
        checks++;
        if (grant_log.size() - g != 4) begin
            errors++;
            $display("FAIL vc0_pop_count: %0d pops, required 4", grant_log.size() - g);
        end
        checks++;
        if (push_log.size() - p != 4) begin
            errors++;
            $display("FAIL vc0_push_count: %0d pushes, required 4", push_log.size() - p);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (push_log[p + k] !== want[k]) begin
                    errors++;
                    $display("FAIL vc0_dst_seq: push %0d dst=%b, required %b", k, push_log[p + k], want[k]);
                end
            end
        end
        checks++;
        if (cnt_vc0 !== (CNT_EN ? 8'(pushed0) : 8'd0)) begin
            errors++;
            $display("FAIL cnt_vc0_stream: cnt_vc0=%0d, required %0d", cnt_vc0, CNT_EN ? 8'(pushed0) : 8'd0);
        end
    endtask

    task automatic test_starve();
        int g, n0, run, maxrun;
        g = grant_log.size();
        for (int i = 0; i < 6; i++) begin
            load(0, 8'(i * 65 + 17));
            load(1, 8'(i * 71 + 200));
        end
        wait_drain(80, "starve");
        checks++;
        if (grant_log.size() - g != 12) begin
            errors++;
            $display("FAIL starve_total: %0d grants, required 12", grant_log.size() - g);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (grant_log[g + k] != ((k == 4) ? 1 : 0)) begin
                    errors++;
                    $display("FAIL starve_order: grant %0d to vc%0d, required vc%0d", k, grant_log[g + k], (k == 4) ? 1 : 0);
                end
            end
            n0 = 0; run = 0; maxrun = 0;
            for (int k = 0; k < 12; k++) begin
                if (grant_log[g + k] == 0) begin
                    n0++; run++;
                    if (run > maxrun) maxrun = run;
                end else begin
                    run = 0;
                end
            end
            checks++;
            if (n0 != 6) begin
                errors++;
                $display("FAIL starve_vc0_count: %0d vc0 grants, required 6", n0);
            end
            checks++;
            if (maxrun > 4) begin
                errors++;
                $display("FAIL starve_run: %0d consecutive vc0 grants, required at most 4", maxrun);
            end
        end
    endtask

    task automatic test_pause();
        int g, p, n;
        for (int i = 0; i < 6; i++) load(0, 8'(i * 37 + 32));
        g = grant_log.size();
        n = 0;
        while (grant_log.size() < g + 2 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (grant_log.size() < g + 2) begin
            errors++;
            $display("FAIL pause_start: %0d pops seen, required 2", grant_log.size() - g);
        end
        almost_full_dst = 4'b0100;
        #1;
        checks++;
        if ({pop_vc0, pop_vc1} !== 2'b00) begin
            errors++;
            $display("FAIL pause_same_cycle: pops=%b%b, required 00", pop_vc0, pop_vc1);
        end
        p = push_log.size();
        g = grant_log.size();
        tick();
        checks++;
        if (arb_state !== 2'd2) begin
            errors++;
            $display("FAIL pause_hold: arb_state=%0d, required 2", arb_state);
        end
        repeat (4) tick();
        checks++;
        if (grant_log.size() != g) begin
            errors++;
            $display("FAIL pause_no_pop: %0d pops while paused, required 0", grant_log.size() - g);
        end
        checks++;
        if (push_log.size() - p > 2) begin
            errors++;
            $display("FAIL pause_inflight: %0d pushes after pause, required at most 2", push_log.size() - p);
        end
        almost_full_dst = 4'b0000;
        #1;
        checks++;
        if (pop_vc0 !== 1'b0) begin
            errors++;
            $display("FAIL pause_release_same: pop_vc0=%b, required 0", pop_vc0);
        end
        tick();
        checks++;
        if (pop_vc0 !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume: pop_vc0=%b, required 1", pop_vc0);
        end
        wait_drain(40, "pause");
    endtask

    task automatic test_single_vc1();
        int g, p;
        g = grant_log.size();
        p = push_log.size();
        load(1, 8'h9C);
        wait_drain(20, "single_vc1");
        checks++;
        if (grant_log.size() - g != 1) begin
            errors++;
            $display("FAIL single_pop_count: %0d pops, required 1", grant_log.size() - g);
        end else begin
            checks++;
            if (grant_log[g] != 1) begin
                errors++;
                $display("FAIL single_pop_vc: popped vc%0d, required vc1", grant_log[g]);
            end
        end
        checks++;
        if (push_log.size() - p != 1) begin
            errors++;
            $display("FAIL single_push_count: %0d pushes, required 1", push_log.size() - p);
        end else begin
            checks++;
            if (push_log[p] !== 4'b0100) begin
                errors++;
                $display("FAIL single_push_dst: dst=%b, required 0100", push_log[p]);
            end
        end
    endtask

    task automatic test_reset_inflight();
        int g, p, n;
        g = grant_log.size();
        load(0, 8'h41); load(0, 8'h82); load(0, 8'hC3);
        n = 0;
        while (grant_log.size() < g + 1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (push_dst !== 4'b0010) begin
            errors++;
            $display("FAIL inflight_pre: push_dst=%b before reset, required 0010", push_dst);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({pop_vc0, pop_vc1, push_dst, data_out, arb_state, cnt_vc0, cnt_vc1} !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: pops=%b%b push=%b data=%h state=%0d cnt=%0d/%0d, required all 0", pop_vc0, pop_vc1, push_dst, data_out, arb_state, cnt_vc0, cnt_vc1);
        end
        p = push_log.size();
        repeat (3) tick();
        checks++;
        if (push_log.size() != p || push_dst !== 4'b0000) begin
            errors++;
            $display("FAIL reset_no_push: %0d pushes during reset, push_dst=%b, required none", push_log.size() - p, push_dst);
        end
        reset = 1'b0;
        wait_drain(20, "post_reset");
        checks++;
        if (cnt_vc0 !== (CNT_EN ? 8'(pushed0) : 8'd0)) begin
            errors++;
            $display("FAIL cnt_after_reset: cnt_vc0=%0d, required %0d", cnt_vc0, CNT_EN ? 8'(pushed0) : 8'd0);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (cnt_vc0 !== 8'd0 || cnt_vc1 !== 8'd0) begin
            errors++;
            $display("FAIL wrap_start: cnt=%0d/%0d, required 0/0", cnt_vc0, cnt_vc1);
        end
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 4; k++) load(0, 8'(i * 4 + k));
            wait_drain(30, "wrap");
            if (i == 31) begin
                checks++;
                if (cnt_vc0 !== (CNT_EN ? 8'd128 : 8'd0)) begin
                    errors++;
                    $display("FAIL wrap_mid: cnt_vc0=%0d, required %0d", cnt_vc0, CNT_EN ? 8'd128 : 8'd0);
                end
            end
        end
        checks++;
        if (pushed0 != 256) begin
            errors++;
            $display("FAIL wrap_pushes: %0d vc0 pushes, required 256", pushed0);
        end
        checks++;
        if (cnt_vc0 !== 8'd0 || cnt_vc1 !== 8'd0) begin
            errors++;
            $display("FAIL wrap_end: cnt=%0d/%0d, required 0/0", cnt_vc0, cnt_vc1);
        end
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0;
        pushed0 = 0; pushed1 = 0;
        wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0;
        lat0 = 1'b0; lat1 = 1'b0;
        reset = 1'b1;
        almost_full_dst = 4'b0000;
        data_vc0 = 8'h00;
        data_vc1 = 8'h00;

        test_reset();
        test_vc0_stream();
        test_starve();
        test_pause();
        test_single_vc1();
        test_reset_inflight();
        test_wrap();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
